// File: rtl/change_pkg.sv
// ---------------------------------------------------------------------------
// change_pkg
//   Shared types and default denominations for the change-return path.
//   Used by change_dispenser and change_inventory.
//   No ports.
// ---------------------------------------------------------------------------
package change_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      REQ,
      DONE
   } state_t;

   typedef enum logic [1:0] {
      NONE,
      NOTE,
      COIN
   } item_t;

   localparam int DEF_MONEY_W    = 5;
   localparam int DEF_NOTE_VAL   = 10;
   localparam int DEF_COIN_VAL   = 2;
   localparam int DEF_NOTE_STOCK = 4;
   localparam int DEF_COIN_STOCK = 15;

endpackage

// File: rtl/change_inventory.sv
// ---------------------------------------------------------------------------
// change_inventory
//   Note and coin stock counters for the change dispenser. Each counter loads
//   its stock on reset, decrements on every acknowledged item of its kind and
//   saturates at zero. Only built when CHANGE_INVENTORY_EN is defined.
// Ports
//   clk_i         in   clock, rising edge
//   rst_i         in   asynchronous active-high reset (reloads the stock)
//   take_note_i   in   one note has been released
//   take_coin_i   in   one coin has been released
//   note_avail_o  out  at least one note left
//   coin_avail_o  out  at least one coin left
// ---------------------------------------------------------------------------
module change_inventory
   import change_pkg::*;
#(
   parameter int NOTE_STOCK = DEF_NOTE_STOCK,
   parameter int COIN_STOCK = DEF_COIN_STOCK
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic take_note_i,
   input  logic take_coin_i,
   output logic note_avail_o,
   output logic coin_avail_o
);

   localparam int MAX_STOCK = (NOTE_STOCK > COIN_STOCK) ? NOTE_STOCK : COIN_STOCK;
   // +2 keeps the width at least one bit even for an empty stock
   localparam int CW        = $clog2(MAX_STOCK + 2);

   logic [1:0] take;
   logic [1:0] avail;

   assign take         = {take_coin_i, take_note_i};
   assign note_avail_o = avail[0];
   assign coin_avail_o = avail[1];

   // Channel 0 counts notes, channel 1 counts coins
   for (genvar gi = 0; gi < 2; gi++) begin : g_stock
      localparam int INIT = (gi == 0) ? NOTE_STOCK : COIN_STOCK;

      logic [CW-1:0] cnt_q;

      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            cnt_q <= CW'(INIT);
         end else if (take[gi] && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
         end
      end

      assign avail[gi] = (cnt_q != '0);
   end

endmodule

// File: rtl/change_dispenser.sv
// ---------------------------------------------------------------------------
// change_dispenser
//   Change-return controller. On start it latches price and inserted amount,
//   computes the change and releases it one item at a time (notes first),
//   handshaking each item with the ejector mechanism.
//   Optional feature macro: CHANGE_INVENTORY_EN (finite note/coin stock).
// Ports
//   clk_i            in   clock, rising edge
//   rst_i            in   asynchronous active-high reset
//   start_i          in   one-cycle request, sampled only in IDLE
//   value_to_pay_i   in   price, sampled with start
//   input_money_i    in   amount inserted, sampled with start
//   note_out_o       out  note request, held until dispense_ack_i
//   coin_out_o       out  coin request, held until dispense_ack_i
//   dispense_ack_i   in   mechanism released the requested item
//   busy_o           out  high outside IDLE
//   done_o           out  one-cycle end-of-transaction pulse
//   error_o          out  pulses with done on underpay or stock shortage
//   residue_o        out  undispensed remainder, valid with done, held after
// ---------------------------------------------------------------------------
module change_dispenser
   import change_pkg::*;
#(
   parameter int MONEY_W    = DEF_MONEY_W,
   parameter int NOTE_VAL   = DEF_NOTE_VAL,
   parameter int COIN_VAL   = DEF_COIN_VAL
`ifdef CHANGE_INVENTORY_EN
   ,
   parameter int NOTE_STOCK = DEF_NOTE_STOCK,
   parameter int COIN_STOCK = DEF_COIN_STOCK
`endif
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               start_i,
   input  logic [MONEY_W-1:0] value_to_pay_i,
   input  logic [MONEY_W-1:0] input_money_i,
   output logic               note_out_o,
   output logic               coin_out_o,
   input  logic               dispense_ack_i,
   output logic               busy_o,
   output logic               done_o,
   output logic               error_o,
   output logic [MONEY_W-1:0] residue_o
);

   localparam logic [MONEY_W-1:0] NOTE_V = MONEY_W'(NOTE_VAL);
   localparam logic [MONEY_W-1:0] COIN_V = MONEY_W'(COIN_VAL);

   state_t             state_q;
   item_t              item_q;
   logic [MONEY_W-1:0] price_q;
   logic [MONEY_W-1:0] paid_q;
   logic [MONEY_W-1:0] remaining_q;
   logic               note_q;
   logic               coin_q;
   logic               busy_q;
   logic               done_q;
   logic               error_q;
   logic [MONEY_W-1:0] residue_q;

   logic               note_avail;
   logic               coin_avail;
   logic               acked;
   logic               underpaid;
   logic               stock_short;
   logic               step_stop;
   logic [MONEY_W-1:0] step_val;
   item_t              step_item;

   // An ack counts only while a request is actually on the wire
   assign acked = (state_q == REQ) && (item_q != NONE) && dispense_ack_i;

`ifdef CHANGE_INVENTORY_EN
   change_inventory #(
      .NOTE_STOCK (NOTE_STOCK),
      .COIN_STOCK (COIN_STOCK)
   ) u_inventory (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .take_note_i  (acked && (item_q == NOTE)),
      .take_coin_i  (acked && (item_q == COIN)),
      .note_avail_o (note_avail),
      .coin_avail_o (coin_avail)
   );
`else
   assign note_avail = 1'b1;
   assign coin_avail = 1'b1;
`endif

   // Largest denomination that fits and is in stock; an unavailable note is
   // paid out in coins instead.
   function automatic item_t pick(input logic [MONEY_W-1:0] v,
                                  input logic n_ok,
                                  input logic c_ok);
      item_t r;
      r = NONE;
      if ((v >= NOTE_V) && n_ok) begin
         r = NOTE;
      end else if ((v >= COIN_V) && c_ok) begin
         r = COIN;
      end
      return r;
   endfunction

   // step_val is the amount the next decision is based on: fresh change in
   // CALC, the post-ack amount on an ack, otherwise the held remainder.
   always_comb begin
      underpaid = 1'b0;
      step_val  = remaining_q;
      if (state_q == CALC) begin
         underpaid = (paid_q < price_q);
         step_val  = underpaid ? paid_q : (paid_q - price_q);
      end else if (acked) begin
         step_val = remaining_q - ((item_q == NOTE) ? NOTE_V : COIN_V);
      end
      step_item   = pick(step_val, note_avail, coin_avail);
      stock_short = (step_val >= COIN_V) && (step_item == NONE);
      // An underpaid amount is handed back whole as residue, not dispensed
      step_stop   = underpaid || (step_val < COIN_V) || stock_short;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         item_q      <= NONE;
         price_q     <= '0;
         paid_q      <= '0;
         remaining_q <= '0;
         note_q      <= 1'b0;
         coin_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         residue_q   <= '0;
      end else begin
         done_q  <= 1'b0;
         error_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (start_i) begin
                  price_q <= value_to_pay_i;
                  paid_q  <= input_money_i;
                  busy_q  <= 1'b1;
                  state_q <= CALC;
               end
            end
            CALC, REQ: begin
               // A pending request just waits; every other cycle decides.
               if ((state_q == CALC) || (item_q == NONE) || acked) begin
                  remaining_q <= step_val;
                  if (step_stop) begin
                     item_q    <= NONE;
                     note_q    <= 1'b0;
                     coin_q    <= 1'b0;
                     done_q    <= 1'b1;
                     error_q   <= underpaid || stock_short;
                     residue_q <= step_val;
                     state_q   <= DONE;
                  end else if (acked) begin
                     // Mandatory low cycle between consecutive items
                     item_q <= NONE;
                     note_q <= 1'b0;
                     coin_q <= 1'b0;
                  end else begin
                     item_q  <= step_item;
                     note_q  <= (step_item == NOTE);
                     coin_q  <= (step_item == COIN);
                     state_q <= REQ;
                  end
               end
            end
            DONE: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign note_out_o = note_q;
   assign coin_out_o = coin_q;
   assign busy_o     = busy_q;
   assign done_o     = done_q;
   assign error_o    = error_q;
   assign residue_o  = residue_q;

endmodule
